// File: rtl/avalon_sram_bridge.sv
// rtl/avalon_sram_bridge.sv - Avalon-MM slave to asynchronous SRAM bridge with pipelined in-order reads
module avalon_sram_bridge #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 18,
    parameter int CMD_DEPTH     = 4,
    parameter int RSP_DEPTH     = 4,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      read_n,
    input  logic                      write_n,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH-1:0]     writeData,
    input  logic [DATA_WIDTH/8-1:0]   byteEnable_n,
    output logic                      waitrequest,
    output logic [DATA_WIDTH-1:0]     readData,
    output logic                      readdatavalid,
    inout  wire  [DATA_WIDTH-1:0]     dq_sram,
    output logic [ADDR_WIDTH-1:0]     address_sram,
    output logic                      ce_n_sram,
    output logic                      oe_n_sram,
    output logic                      we_n_sram,
    output logic [DATA_WIDTH/8-1:0]   be_n_sram
);
    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int CMD_W  = 1 + ADDR_WIDTH + DATA_WIDTH + BE_W;
    localparam int CPTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CCNT_W = $clog2(CMD_DEPTH + 1);
    localparam int RPTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int RCNT_W = $clog2(RSP_DEPTH + 1);
    localparam int CYC_W  = 4;

    typedef enum logic [1:0] {IDLE, TURN, ACCESS, HOLD} state_e;

    // Command FIFO
    logic [CMD_W-1:0]      cmdMem [CMD_DEPTH];
    logic [CPTR_W-1:0]     cmdWr, cmdRd;
    logic [CCNT_W-1:0]     cmdCount;
    logic                  cmdEmpty, cmdFull, cmdPop, accept, acceptRead;
    logic                  headIsRead;
    logic [ADDR_WIDTH-1:0] headAddr;
    logic [DATA_WIDTH-1:0] headData;
    logic [BE_W-1:0]       headBe;

    // Response FIFO and read credits
    logic [DATA_WIDTH-1:0] rspMem [RSP_DEPTH];
    logic [RPTR_W-1:0]     rspWr, rspRd;
    logic [RCNT_W-1:0]     rspCount, outstanding;
    logic                  rspPush;

    // SRAM sequencer
    state_e                state, nextState;
    logic [CYC_W-1:0]      cycCnt, nextCnt;
    logic                  lastCycle;
    logic                  curIsRead;
    logic [ADDR_WIDTH-1:0] curAddr;
    logic [DATA_WIDTH-1:0] curData;
    logic [BE_W-1:0]       curBe;
    logic                  selIsRead;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [DATA_WIDTH-1:0] selData;
    logic [BE_W-1:0]       selBe;
    logic                  dqOe;
    logic [DATA_WIDTH-1:0] dqOut;

    assign cmdEmpty      = (cmdCount == '0);
    assign cmdFull       = (cmdCount == CCNT_W'(CMD_DEPTH));
    assign waitrequest   = rst | cmdFull | (outstanding == RCNT_W'(RSP_DEPTH));
    assign accept        = !waitrequest && (!read_n || !write_n);
    assign acceptRead    = accept && !read_n;
    assign {headIsRead, headAddr, headData, headBe} = cmdMem[cmdRd];
    assign readdatavalid = (rspCount != '0);
    assign readData      = readdatavalid ? rspMem[rspRd] : '0;
    assign lastCycle     = (cycCnt == CYC_W'(ACCESS_CYCLES - 1));
    assign dq_sram       = dqOe ? dqOut : {DATA_WIDTH{1'bz}};

    // Command storage; simultaneous read and write requests are treated as reads
    always_ff @(posedge clk) begin
        if (accept) cmdMem[cmdWr] <= {!read_n, address, writeData, byteEnable_n};
    end

    // Command FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            cmdWr    <= '0;
            cmdRd    <= '0;
            cmdCount <= '0;
        end else begin
            if (accept) cmdWr <= (cmdWr == CPTR_W'(CMD_DEPTH - 1)) ? '0 : cmdWr + 1'b1;
            if (cmdPop) cmdRd <= (cmdRd == CPTR_W'(CMD_DEPTH - 1)) ? '0 : cmdRd + 1'b1;
            cmdCount <= cmdCount + CCNT_W'(accept) - CCNT_W'(cmdPop);
        end
    end

    // Read data captured from the SRAM bus at the final access edge
    always_ff @(posedge clk) begin
        if (rspPush) rspMem[rspWr] <= dq_sram;
    end

    // Response FIFO drains one word per cycle; outstanding counts reads not yet returned
    always_ff @(posedge clk) begin
        if (rst) begin
            rspWr       <= '0;
            rspRd       <= '0;
            rspCount    <= '0;
            outstanding <= '0;
        end else begin
            if (rspPush) rspWr <= (rspWr == RPTR_W'(RSP_DEPTH - 1)) ? '0 : rspWr + 1'b1;
            if (readdatavalid) rspRd <= (rspRd == RPTR_W'(RSP_DEPTH - 1)) ? '0 : rspRd + 1'b1;
            rspCount    <= rspCount + RCNT_W'(rspPush) - RCNT_W'(readdatavalid);
            outstanding <= outstanding + RCNT_W'(acceptRead) - RCNT_W'(readdatavalid);
        end
    end

    // Next-state logic: turnaround on direction change, gapless read bursts, write hold cycle
    always_comb begin
        nextState = state;
        nextCnt   = cycCnt;
        cmdPop    = 1'b0;
        rspPush   = 1'b0;
        case (state)
            IDLE: begin
                if (!cmdEmpty) begin
                    cmdPop    = 1'b1;
                    nextState = (headIsRead != curIsRead) ? TURN : ACCESS;
                end
            end
            TURN: nextState = ACCESS;
            ACCESS: begin
                if (!lastCycle) begin
                    nextCnt = cycCnt + 1'b1;
                end else if (curIsRead) begin
                    rspPush = 1'b1;
                    if (!cmdEmpty) begin
                        cmdPop    = 1'b1;
                        nextState = headIsRead ? ACCESS : TURN;
                    end else begin
                        nextState = IDLE;
                    end
                end else begin
                    nextState = HOLD;
                end
            end
            HOLD: begin
                if (!cmdEmpty && !headIsRead) begin
                    cmdPop    = 1'b1;
                    nextState = ACCESS;
                end else begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
        if (cmdPop || state == TURN) nextCnt = '0;
        selIsRead = cmdPop ? headIsRead : curIsRead;
        selAddr   = cmdPop ? headAddr   : curAddr;
        selData   = cmdPop ? headData   : curData;
        selBe     = cmdPop ? headBe     : curBe;
    end

    // State, current command and registered SRAM pins derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cycCnt       <= '0;
            curIsRead    <= 1'b1;
            curAddr      <= '0;
            curData      <= '0;
            curBe        <= '1;
            ce_n_sram    <= 1'b1;
            oe_n_sram    <= 1'b1;
            we_n_sram    <= 1'b1;
            address_sram <= '0;
            be_n_sram    <= '1;
            dqOe         <= 1'b0;
            dqOut        <= '0;
        end else begin
            state  <= nextState;
            cycCnt <= nextCnt;
            if (cmdPop) begin
                curIsRead <= headIsRead;
                curAddr   <= headAddr;
                curData   <= headData;
                curBe     <= headBe;
            end
            ce_n_sram <= !(nextState == ACCESS || nextState == HOLD);
            oe_n_sram <= !(nextState == ACCESS && selIsRead);
            we_n_sram <= !(nextState == ACCESS && !selIsRead);
            dqOe      <= (nextState == ACCESS && !selIsRead) || nextState == HOLD;
            if (nextState == ACCESS) begin
                address_sram <= selAddr;
                be_n_sram    <= selBe;
                dqOut        <= selData;
            end else if (nextState != HOLD) begin
                be_n_sram <= '1;
            end
        end
    end
endmodule

// File: tb/tb_avalon_sram_bridge.sv
// tb/tb_avalon_sram_bridge.sv - scoreboard testbench for avalon_sram_bridge
module tb_avalon_sram_bridge;
    localparam int DW = 16;
    localparam int AW = 18;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          read_n, write_n;
    logic [AW-1:0] address;
    logic [DW-1:0] writeData;
    logic [BW-1:0] byteEnable_n;
    logic          waitrequest;
    logic [DW-1:0] readData;
    logic          readdatavalid;
    wire  [DW-1:0] dq_sram;
    logic [AW-1:0] address_sram;
    logic          ce_n_sram, oe_n_sram, we_n_sram;
    logic [BW-1:0] be_n_sram;

    avalon_sram_bridge #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CMD_DEPTH(4), .RSP_DEPTH(4), .ACCESS_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .read_n(read_n), .write_n(write_n), .address(address),
        .writeData(writeData), .byteEnable_n(byteEnable_n), .waitrequest(waitrequest),
        .readData(readData), .readdatavalid(readdatavalid), .dq_sram(dq_sram),
        .address_sram(address_sram), .ce_n_sram(ce_n_sram), .oe_n_sram(oe_n_sram),
        .we_n_sram(we_n_sram), .be_n_sram(be_n_sram)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: unwritten words read as address + 0x100
    logic [DW-1:0] sramMem [1024];
    bit            written [1024];
    logic [9:0]    idx;
    logic [DW-1:0] sramWord, merged;
    assign idx      = address_sram[9:0];
    assign sramWord = written[idx] ? sramMem[idx] : DW'({22'd0, idx} + 32'h100);
    assign dq_sram  = (!ce_n_sram && !oe_n_sram && we_n_sram) ? sramWord : {DW{1'bz}};

    always_comb begin
        merged = sramWord;
        for (int b = 0; b < BW; b++)
            if (!be_n_sram[b]) merged[b*8 +: 8] = dq_sram[b*8 +: 8];
    end

    always @(posedge clk) begin
        if (!ce_n_sram && !we_n_sram) begin
            sramMem[idx] <= merged;
            written[idx] <= 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] expQ [$];
    int latQ [$];
    int accQ [$];
    int rdvQ [$];
    logic monOn = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every readdatavalid cycle
    always @(negedge clk) begin
        if (monOn && !rst) begin
            if (readdatavalid) begin
                rdvQ.push_back(cyc);
                if (expQ.size() == 0) begin
                    chk("unexpected_readdatavalid", 1, 0);
                end else begin
                    logic [DW-1:0] d;
                    int l, a;
                    d = expQ.pop_front();
                    l = latQ.pop_front();
                    a = accQ.pop_front();
                    chk("readData", readData, d);
                    if (l >= 0) chk("read_latency", cyc - a, l);
                end
            end else begin
                chk("readData_zero_when_invalid", readData, 0);
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be, input logic track,
                         input logic [DW-1:0] expD, input int expL, output int accCyc);
        int   tries = 0;
        logic done  = 1'b0;
        read_n = !rd; write_n = !wr; address = a; writeData = d; byteEnable_n = be;
        accCyc = -1;
        while (!done && tries < 100) begin
            @(negedge clk);
            if (!waitrequest) begin
                done   = 1'b1;
                accCyc = cyc;
                if (track) begin
                    expQ.push_back(expD);
                    latQ.push_back(expL);
                    accQ.push_back(cyc);
                end
            end
            @(posedge clk); #1;
            tries++;
        end
        read_n = 1'b1; write_n = 1'b1;
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) chk("drain_timeout", expQ.size(), 0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    int t;
    int acc [6];
    int latTab [6] = '{4, 5, 6, 7, 7, 7};
    int ceTab  [6] = '{1, 1, 0, 0, 0, 1};
    int weTab  [6] = '{1, 1, 0, 0, 1, 1};
    int found;

    initial begin
        rst = 1'b1; read_n = 1'b1; write_n = 1'b1;
        address = '0; writeData = '0; byteEnable_n = '1;

        // Reset state
        @(negedge clk);
        chk("reset_waitrequest", waitrequest, 1);
        @(negedge clk);
        chk("reset_ce_n", ce_n_sram, 1);
        chk("reset_oe_n", oe_n_sram, 1);
        chk("reset_we_n", we_n_sram, 1);
        chk("reset_be_n", be_n_sram, 2'b11);
        chk("reset_address_sram", address_sram, 0);
        chk("reset_readdatavalid", readdatavalid, 0);
        chk("reset_readData", readData, 0);
        chk("reset_dq_released", (dq_sram === {DW{1'bz}}) ? 1 : 0, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        monOn = 1'b1;
        @(negedge clk);
        chk("post_reset_waitrequest", waitrequest, 0);
        @(posedge clk); #1;

        // Both read_n and write_n low: treated as a read
        issue(1'b1, 1'b1, 18'h00005, 16'hDEAD, 2'b00, 1'b1, 16'h0105, 4, t);
        @(negedge clk);
        @(negedge clk);
        chk("both_low_oe_n", oe_n_sram, 0);
        chk("both_low_we_n", we_n_sram, 1);
        chk("both_low_ce_n", ce_n_sram, 0);
        chk("both_low_address", address_sram, 18'h00005);
        @(negedge clk);
        chk("both_low_we_n_2", we_n_sram, 1);
        waitIdle();

        // Six back-to-back reads against the credit limit
        rdvQ.delete();
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, 1'b0, AW'(32 + i), 16'h0, 2'b00, 1'b1, DW'(32 + i + 256), latTab[i], acc[i]);
            if (i == 3) chk("waitrequest_after_4th_accept", waitrequest, 1);
        end
        chk("fifth_accept_gap", acc[4] - acc[0], 5);
        waitIdle();
        chk("burst_response_count", rdvQ.size(), 6);
        for (int i = 1; i < 6; i++)
            if (i < rdvQ.size()) chk("burst_read_spacing", rdvQ[i] - rdvQ[i-1], 2);

        // Single write after reads: turnaround, 2 strobe cycles, 1 hold cycle
        issue(1'b0, 1'b1, 18'h00012, 16'hA5C3, 2'b00, 1'b0, 16'h0, -1, t);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            else @(negedge clk);
            chk("write_ce_n", ce_n_sram, ceTab[k-1]);
            chk("write_we_n", we_n_sram, weTab[k-1]);
            if (k == 3) begin
                chk("write_address_sram", address_sram, 18'h00012);
                chk("write_be_n", be_n_sram, 2'b00);
                chk("write_dq", dq_sram, 16'hA5C3);
                chk("write_oe_n", oe_n_sram, 1);
            end
            if (k == 5) chk("hold_dq", dq_sram, 16'hA5C3);
            if (k == 2 || k == 6) chk("write_dq_released", (dq_sram === {DW{1'bz}}) ? 1 : 0, 1);
        end
        @(posedge clk); #1;

        // Read back after write: turnaround adds one cycle
        issue(1'b1, 1'b0, 18'h00012, 16'h0, 2'b00, 1'b1, 16'hA5C3, 5, t);
        @(negedge clk);
        @(negedge clk);
        chk("turn_ce_n", ce_n_sram, 1);
        chk("turn_dq_released", (dq_sram === {DW{1'bz}}) ? 1 : 0, 1);
        @(negedge clk);
        chk("turn_then_oe_n", oe_n_sram, 0);
        waitIdle();

        // Byte lanes: partial write over 0x1234
        issue(1'b0, 1'b1, 18'h00040, 16'h1234, 2'b00, 1'b0, 16'h0, -1, t);
        issue(1'b0, 1'b1, 18'h00040, 16'hFFFF, 2'b10, 1'b0, 16'h0, -1, t);
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            @(negedge clk);
            if (!we_n_sram && address_sram == 18'h00040 && dq_sram == 16'hFFFF) begin
                found = 1;
                chk("partial_be_n", be_n_sram, 2'b10);
            end
        end
        chk("partial_write_seen", found, 1);
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 18'h00040, 16'h0, 2'b00, 1'b1, 16'h12FF, -1, t);
        waitIdle();

        // Reset in the middle of a read access
        issue(1'b1, 1'b0, 18'h00030, 16'h0, 2'b00, 1'b0, 16'h0, -1, t);
        found = 0;
        for (int n = 0; n < 10 && found == 0; n++) begin
            @(negedge clk);
            if (!oe_n_sram) found = 1;
        end
        chk("mid_read_access_seen", found, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_waitrequest", waitrequest, 1);
            if (i > 0) begin
                chk("rst_ce_n", ce_n_sram, 1);
                chk("rst_oe_n", oe_n_sram, 1);
                chk("rst_we_n", we_n_sram, 1);
                chk("rst_readdatavalid", readdatavalid, 0);
                chk("rst_dq_released", (dq_sram === {DW{1'bz}}) ? 1 : 0, 1);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_waitrequest", waitrequest, 0);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;

        // Direction history resets to read: no turnaround
        issue(1'b1, 1'b0, 18'h00007, 16'h0, 2'b00, 1'b1, 16'h0107, 4, t);
        waitIdle();
        chk("scoreboard_drained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
